// File: rtl/flow_ctrl_if.sv
// Control-flow sequencer bundle: pipeline-side requests into flow_ctrl and the
// redirect / flush / hold / interrupt-state results flowing back out.
interface flow_ctrl_if #(
    parameter int PC_W = 16
) ();
    // Requests from the pipeline
    logic            flow_change_ID_EX;
    logic            rti_ID_EX;
    logic [PC_W-1:0] dst_pc_EX;
    logic [PC_W-1:0] pc_IF;
    logic [3:0]      PSW;
    logic            stall_mem;
    logic            irq;

    // Results from the sequencer
    logic            redirect_vld;
    logic [PC_W-1:0] redirect_pc;
    logic            flush_IF_ID;
    logic            flush_ID_EX;
    logic            pc_hold;
    logic            irq_ack;
    logic            psw_restore_vld;
    logic [3:0]      psw_restore;
    logic [PC_W-1:0] epc;
    logic            in_isr;

    // Pipeline side: drives requests, observes results
    modport master (
        output flow_change_ID_EX, rti_ID_EX, dst_pc_EX, pc_IF, PSW, stall_mem, irq,
        input  redirect_vld, redirect_pc, flush_IF_ID, flush_ID_EX, pc_hold,
               irq_ack, psw_restore_vld, psw_restore, epc, in_isr
    );

    // Sequencer side: observes requests, drives results
    modport slave (
        input  flow_change_ID_EX, rti_ID_EX, dst_pc_EX, pc_IF, PSW, stall_mem, irq,
        output redirect_vld, redirect_pc, flush_IF_ID, flush_ID_EX, pc_hold,
               irq_ack, psw_restore_vld, psw_restore, epc, in_isr
    );
endinterface

// File: rtl/flow_ctrl.sv
// flow_ctrl: sequences taken branches/jumps, interrupt entry and RTI return.
// Owns EPC, the saved PSW and the in-ISR flag. Every output is a register;
// a memory stall freezes everything and only squashes the one-cycle pulses.
module flow_ctrl #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] VECTOR    = 16'h0001,
    parameter int              FLUSH_CYC = 2,
    parameter int              DRAIN_CYC = 3
) (
    input logic        clk,
    input logic        rst,
    flow_ctrl_if.slave bus
);

    localparam int MAX_CYC = (FLUSH_CYC > DRAIN_CYC) ? FLUSH_CYC : DRAIN_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FLUSH = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_VECTOR = 2'd3
    } state_t;

    state_t          r_state,           w_state_nxt;
    logic [CNT_W-1:0] r_cnt,            w_cnt_nxt;
    logic [PC_W-1:0] r_epc,             w_epc_nxt;
    logic            r_in_isr,          w_in_isr_nxt;
    logic            r_redirect_vld,    w_redirect_vld_nxt;
    logic [PC_W-1:0] r_redirect_pc,     w_redirect_pc_nxt;
    logic            r_flush_if_id,     w_flush_if_id_nxt;
    logic            r_flush_id_ex,     w_flush_id_ex_nxt;
    logic            r_pc_hold,         w_pc_hold_nxt;
    logic            r_irq_ack,         w_irq_ack_nxt;
    logic            r_psw_restore_vld, w_psw_restore_vld_nxt;
    logic [3:0]      r_psw_restore,     w_psw_restore_nxt;

    // Next-state and next-output decode; levels hold by default, pulses drop to 0
    always_comb begin
        w_state_nxt           = r_state;
        w_cnt_nxt             = r_cnt;
        w_epc_nxt             = r_epc;
        w_in_isr_nxt          = r_in_isr;
        w_redirect_vld_nxt    = 1'b0;
        w_redirect_pc_nxt     = r_redirect_pc;
        w_flush_if_id_nxt     = r_flush_if_id;
        w_flush_id_ex_nxt     = r_flush_id_ex;
        w_pc_hold_nxt         = r_pc_hold;
        w_irq_ack_nxt         = 1'b0;
        w_psw_restore_vld_nxt = 1'b0;
        w_psw_restore_nxt     = r_psw_restore;

        if (bus.stall_mem) begin
            // Frozen: everything above already holds, pulses are squashed
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.flow_change_ID_EX) begin
                        // Taken flow change wins over a same-cycle irq
                        w_redirect_vld_nxt = 1'b1;
                        w_redirect_pc_nxt  = bus.rti_ID_EX ? r_epc : bus.dst_pc_EX;
                        w_flush_if_id_nxt  = 1'b1;
                        w_flush_id_ex_nxt  = 1'b1;
                        w_pc_hold_nxt      = 1'b0;
                        w_cnt_nxt          = CNT_FLUSH;
                        w_state_nxt        = ST_FLUSH;
                        if (bus.rti_ID_EX) begin
                            w_psw_restore_vld_nxt = 1'b1;
                            w_in_isr_nxt          = 1'b0;
                        end else begin
                            w_in_isr_nxt = r_in_isr;
                        end
                    end else if (bus.irq && !r_in_isr) begin
                        // Accept interrupt: remember where to return, drain the pipe
                        w_epc_nxt         = bus.pc_IF;
                        w_pc_hold_nxt     = 1'b1;
                        w_flush_if_id_nxt = 1'b1;
                        w_flush_id_ex_nxt = 1'b0;
                        w_cnt_nxt         = CNT_DRAIN;
                        w_state_nxt       = ST_DRAIN;
                    end else begin
                        w_flush_if_id_nxt = 1'b0;
                        w_flush_id_ex_nxt = 1'b0;
                        w_pc_hold_nxt     = 1'b0;
                    end
                end

                ST_FLUSH: begin
                    // ID/EX is squashed here, so any flow_change seen is stale
                    if (r_cnt == CNT_ZERO) begin
                        w_flush_if_id_nxt = 1'b0;
                        w_flush_id_ex_nxt = 1'b0;
                        w_state_nxt       = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end

                ST_DRAIN: begin
                    // A branch still draining retargets the return address
                    if (bus.flow_change_ID_EX) begin
                        w_epc_nxt         = bus.rti_ID_EX ? r_epc : bus.dst_pc_EX;
                        w_flush_id_ex_nxt = 1'b1;
                    end else begin
                        w_flush_id_ex_nxt = 1'b0;
                    end
                    if (r_cnt == CNT_ZERO) begin
                        w_redirect_vld_nxt = 1'b1;
                        w_redirect_pc_nxt  = VECTOR;
                        w_irq_ack_nxt      = 1'b1;
                        w_flush_if_id_nxt  = 1'b1;
                        w_pc_hold_nxt      = 1'b0;
                        w_psw_restore_nxt  = bus.PSW;
                        w_in_isr_nxt       = 1'b1;
                        w_state_nxt        = ST_VECTOR;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end

                ST_VECTOR: begin
                    // Vector outputs were shown this cycle; back to normal flow
                    w_flush_if_id_nxt = 1'b0;
                    w_flush_id_ex_nxt = 1'b0;
                    w_pc_hold_nxt     = 1'b0;
                    w_state_nxt       = ST_RUN;
                end

                default: begin
                    w_flush_if_id_nxt = 1'b0;
                    w_flush_id_ex_nxt = 1'b0;
                    w_pc_hold_nxt     = 1'b0;
                    w_cnt_nxt         = CNT_ZERO;
                    w_state_nxt       = ST_RUN;
                end
            endcase
        end
    end

    // State, bookkeeping and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_RUN;
            r_cnt             <= CNT_ZERO;
            r_epc             <= {PC_W{1'b0}};
            r_in_isr          <= 1'b0;
            r_redirect_vld    <= 1'b0;
            r_redirect_pc     <= {PC_W{1'b0}};
            r_flush_if_id     <= 1'b0;
            r_flush_id_ex     <= 1'b0;
            r_pc_hold         <= 1'b0;
            r_irq_ack         <= 1'b0;
            r_psw_restore_vld <= 1'b0;
            r_psw_restore     <= 4'b0000;
        end else begin
            r_state           <= w_state_nxt;
            r_cnt             <= w_cnt_nxt;
            r_epc             <= w_epc_nxt;
            r_in_isr          <= w_in_isr_nxt;
            r_redirect_vld    <= w_redirect_vld_nxt;
            r_redirect_pc     <= w_redirect_pc_nxt;
            r_flush_if_id     <= w_flush_if_id_nxt;
            r_flush_id_ex     <= w_flush_id_ex_nxt;
            r_pc_hold         <= w_pc_hold_nxt;
            r_irq_ack         <= w_irq_ack_nxt;
            r_psw_restore_vld <= w_psw_restore_vld_nxt;
            r_psw_restore     <= w_psw_restore_nxt;
        end
    end

    assign bus.redirect_vld    = r_redirect_vld;
    assign bus.redirect_pc     = r_redirect_pc;
    assign bus.flush_IF_ID     = r_flush_if_id;
    assign bus.flush_ID_EX     = r_flush_id_ex;
    assign bus.pc_hold         = r_pc_hold;
    assign bus.irq_ack         = r_irq_ack;
    assign bus.psw_restore_vld = r_psw_restore_vld;
    assign bus.psw_restore     = r_psw_restore;
    assign bus.epc             = r_epc;
    assign bus.in_isr          = r_in_isr;

endmodule

// File: tb/tb_flow_ctrl.sv
// Bench for flow_ctrl: directed scenarios followed by random traffic, every
// cycle compared against a remaining-cycles behavioural model of the sequencer.
module tb_flow_ctrl;

    localparam int              FLUSH_CYC = 2;
    localparam int              DRAIN_CYC = 3;
    localparam logic [15:0]     VEC       = 16'h0001;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    flow_ctrl_if #(.PC_W(16)) bif ();

    flow_ctrl #(
        .PC_W      (16),
        .VECTOR    (VEC),
        .FLUSH_CYC (FLUSH_CYC),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what the sequencer promises, tracked as
    // "cycles of flush / drain still to show" plus a vector-shown flag.
    logic        m_redirect_vld, m_flush_if_id, m_flush_id_ex, m_pc_hold;
    logic        m_irq_ack, m_psw_restore_vld, m_in_isr;
    logic [15:0] m_redirect_pc, m_epc;
    logic [3:0]  m_psw_restore;
    int          m_flush_rem, m_drain_rem;
    bit          m_vec_shown;

    task automatic model_reset();
        m_redirect_vld = 1'b0; m_flush_if_id = 1'b0; m_flush_id_ex = 1'b0;
        m_pc_hold = 1'b0; m_irq_ack = 1'b0; m_psw_restore_vld = 1'b0;
        m_in_isr = 1'b0; m_redirect_pc = 16'h0000; m_epc = 16'h0000;
        m_psw_restore = 4'b0000; m_flush_rem = 0; m_drain_rem = 0; m_vec_shown = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            m_redirect_vld = 1'b0; m_irq_ack = 1'b0; m_psw_restore_vld = 1'b0;
            if (!bif.stall_mem) begin
                if (m_vec_shown) begin
                    m_vec_shown = 1'b0;
                    m_flush_if_id = 1'b0; m_flush_id_ex = 1'b0; m_pc_hold = 1'b0;
                end else if (m_flush_rem > 0) begin
                    m_flush_rem--;
                    if (m_flush_rem == 0) begin
                        m_flush_if_id = 1'b0; m_flush_id_ex = 1'b0;
                    end
                end else if (m_drain_rem > 0) begin
                    if (bif.flow_change_ID_EX) begin
                        if (!bif.rti_ID_EX) m_epc = bif.dst_pc_EX;
                        m_flush_id_ex = 1'b1;
                    end else begin
                        m_flush_id_ex = 1'b0;
                    end
                    m_drain_rem--;
                    if (m_drain_rem == 0) begin
                        m_redirect_vld = 1'b1; m_redirect_pc = VEC; m_irq_ack = 1'b1;
                        m_flush_if_id = 1'b1; m_pc_hold = 1'b0;
                        m_psw_restore = bif.PSW; m_in_isr = 1'b1; m_vec_shown = 1'b1;
                    end
                end else if (bif.flow_change_ID_EX) begin
                    m_redirect_vld = 1'b1;
                    m_redirect_pc  = bif.rti_ID_EX ? m_epc : bif.dst_pc_EX;
                    m_flush_if_id  = 1'b1; m_flush_id_ex = 1'b1;
                    m_flush_rem    = FLUSH_CYC;
                    if (bif.rti_ID_EX) begin
                        m_psw_restore_vld = 1'b1; m_in_isr = 1'b0;
                    end
                end else if (bif.irq && !m_in_isr) begin
                    m_epc = bif.pc_IF; m_drain_rem = DRAIN_CYC;
                    m_pc_hold = 1'b1; m_flush_if_id = 1'b1; m_flush_id_ex = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("redirect_vld",    16'(bif.redirect_vld),    16'(m_redirect_vld));
        chk("redirect_pc",     bif.redirect_pc,          m_redirect_pc);
        chk("flush_IF_ID",     16'(bif.flush_IF_ID),     16'(m_flush_if_id));
        chk("flush_ID_EX",     16'(bif.flush_ID_EX),     16'(m_flush_id_ex));
        chk("pc_hold",         16'(bif.pc_hold),         16'(m_pc_hold));
        chk("irq_ack",         16'(bif.irq_ack),         16'(m_irq_ack));
        chk("psw_restore_vld", 16'(bif.psw_restore_vld), 16'(m_psw_restore_vld));
        chk("psw_restore",     16'(bif.psw_restore),     16'(m_psw_restore));
        chk("epc",             bif.epc,                  m_epc);
        chk("in_isr",          16'(bif.in_isr),          16'(m_in_isr));
    endtask

    // One clock: inputs already driven, model follows the edge, outputs checked 1ns later
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int hold_cnt;
        n_assert = 0;
        n_fail   = 0;
        model_reset();
        bif.flow_change_ID_EX = 1'b1; bif.rti_ID_EX = 1'b0; bif.dst_pc_EX = 16'h00AA;
        bif.pc_IF = 16'h0000; bif.PSW = 4'b0000; bif.stall_mem = 1'b0; bif.irq = 1'b1;

        // Reset held two cycles with irq and flow_change asserted
        rst = 1'b1;
        cyc();
        chk("rst_redirect_vld", 16'(bif.redirect_vld), 16'h0000);
        cyc();
        chk("rst_pc_hold", 16'(bif.pc_hold), 16'h0000);
        chk("rst_epc", bif.epc, 16'h0000);
        rst = 1'b0; bif.irq = 1'b0; bif.flow_change_ID_EX = 1'b0;
        cyc();
        chk("post_rst_no_redirect", 16'(bif.redirect_vld), 16'h0000);

        // Taken branch to 0x0040
        bif.flow_change_ID_EX = 1'b1; bif.dst_pc_EX = 16'h0040;
        cyc();
        chk("br_redirect_vld", 16'(bif.redirect_vld), 16'h0001);
        chk("br_redirect_pc", bif.redirect_pc, 16'h0040);
        chk("br_flush_t1", 16'({bif.flush_IF_ID, bif.flush_ID_EX}), 16'h0003);
        bif.flow_change_ID_EX = 1'b0;
        cyc();
        chk("br_flush_t2", 16'({bif.flush_IF_ID, bif.flush_ID_EX}), 16'h0003);
        chk("br_pulse_t2", 16'(bif.redirect_vld), 16'h0000);
        cyc();
        chk("br_flush_t3", 16'({bif.flush_IF_ID, bif.flush_ID_EX}), 16'h0000);

        // Interrupt entry from pc_IF=0x0010 with PSW=0101
        bif.pc_IF = 16'h0010; bif.irq = 1'b1; bif.PSW = 4'b0101;
        cyc();
        chk("irq_hold_t1", 16'(bif.pc_hold), 16'h0001);
        bif.irq = 1'b0;
        cyc();
        chk("irq_hold_t2", 16'(bif.pc_hold), 16'h0001);
        cyc();
        chk("irq_hold_t3", 16'(bif.pc_hold), 16'h0001);
        cyc();
        chk("vec_redirect_pc", bif.redirect_pc, 16'h0001);
        chk("vec_irq_ack", 16'(bif.irq_ack), 16'h0001);
        chk("vec_in_isr", 16'(bif.in_isr), 16'h0001);
        chk("vec_epc", bif.epc, 16'h0010);
        chk("vec_psw", 16'(bif.psw_restore), 16'h0005);
        chk("vec_pc_hold", 16'(bif.pc_hold), 16'h0000);
        bif.PSW = 4'b1010;
        cyc();

        // RTI inside the handler
        bif.flow_change_ID_EX = 1'b1; bif.rti_ID_EX = 1'b1; bif.dst_pc_EX = 16'hBEEF;
        cyc();
        chk("rti_redirect_pc", bif.redirect_pc, 16'h0010);
        chk("rti_psw_vld", 16'(bif.psw_restore_vld), 16'h0001);
        chk("rti_psw", 16'(bif.psw_restore), 16'h0005);
        chk("rti_in_isr", 16'(bif.in_isr), 16'h0000);
        bif.flow_change_ID_EX = 1'b0; bif.rti_ID_EX = 1'b0;
        cyc();
        cyc();
        bif.pc_IF = 16'h0022; bif.irq = 1'b1;
        cyc();
        chk("irq2_accepted", 16'(bif.pc_hold), 16'h0001);
        chk("irq2_epc", bif.epc, 16'h0022);
        bif.irq = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("irq2_ack", 16'(bif.irq_ack), 16'h0001);
        cyc();
        bif.irq = 1'b1;
        cyc();
        chk("nested_irq_ignored", 16'(bif.pc_hold), 16'h0000);
        bif.irq = 1'b0;

        // Branch arriving while draining
        rst = 1'b1;
        cyc();
        rst = 1'b0; bif.pc_IF = 16'h0030; bif.irq = 1'b1;
        cyc();
        bif.irq = 1'b0;
        cyc();
        bif.flow_change_ID_EX = 1'b1; bif.dst_pc_EX = 16'h0080;
        cyc();
        chk("drbr_epc", bif.epc, 16'h0080);
        chk("drbr_flush_id_ex", 16'(bif.flush_ID_EX), 16'h0001);
        chk("drbr_no_redirect", 16'(bif.redirect_vld), 16'h0000);
        bif.flow_change_ID_EX = 1'b0;
        cyc();
        chk("drbr_vec_ack", 16'(bif.irq_ack), 16'h0001);
        chk("drbr_vec_epc", bif.epc, 16'h0080);

        // Simultaneous irq and branch, then a stall mid-drain
        rst = 1'b1;
        cyc();
        rst = 1'b0; bif.irq = 1'b1; bif.flow_change_ID_EX = 1'b1; bif.dst_pc_EX = 16'h0050;
        cyc();
        chk("sim_redirect_pc", bif.redirect_pc, 16'h0050);
        chk("sim_no_hold", 16'(bif.pc_hold), 16'h0000);
        bif.flow_change_ID_EX = 1'b0;
        cyc();
        cyc();
        chk("sim_after_flush_hold", 16'(bif.pc_hold), 16'h0000);
        cyc();
        chk("sim_irq_entered", 16'(bif.pc_hold), 16'h0001);
        bif.irq = 1'b0;
        hold_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            if (bif.pc_hold === 1'b1) hold_cnt++;
            bif.stall_mem = (k >= 2 && k <= 4) ? 1'b1 : 1'b0;
            cyc();
        end
        bif.stall_mem = 1'b0;
        chk("stall_hold_len", 16'(hold_cnt), 16'(DRAIN_CYC + 3));

        // Reset in the middle of a drain
        rst = 1'b1;
        cyc();
        rst = 1'b0; bif.pc_IF = 16'h0066; bif.irq = 1'b1;
        cyc();
        bif.irq = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_epc", bif.epc, 16'h0000);
        chk("midrst_hold", 16'(bif.pc_hold), 16'h0000);
        rst = 1'b0;
        cyc();
        chk("midrst_no_redirect", 16'(bif.redirect_vld), 16'h0000);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst                   = ($urandom_range(0, 199) == 0);
            bif.flow_change_ID_EX = ($urandom_range(0, 4) == 0);
            bif.rti_ID_EX         = ($urandom_range(0, 2) == 0);
            bif.dst_pc_EX         = 16'($urandom);
            bif.pc_IF             = 16'($urandom);
            bif.PSW               = 4'($urandom);
            bif.stall_mem         = ($urandom_range(0, 7) == 0);
            bif.irq               = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
